// File: rtl/mem_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl_if
// Bundle between the multicycle memory-access sequencer, the control FSM that
// issues requests, and the unified instruction/data memory.
//
// Signal summary (direction as seen by the sequencer, modport slave):
//   REQ      in   access request (level), sampled only while idle
//   IOD      in   0 = instruction fetch at PC, 1 = data access at ALUOUT
//   WR       in   1 = store (only meaningful with IOD=1)
//   PC       in   program counter, byte address
//   ALUOUT   in   data address, byte address
//   WDATA    in   store data
//   MRD      in   memory read data (combinational from MRA)
//   MRA      out  memory word address (registered)
//   MWE      out  memory write enable
//   MWD      out  memory write data (registered)
//   IR       out  instruction register
//   MDR      out  memory data register
//   BUSY     out  access in progress
//   DONE     out  one-cycle completion pulse
//   ERR      out  last access faulted (valid with DONE, held until next request)
//   ACC_CNT  out  count of completed non-faulting accesses (wraps)
// CNT_W must match the CNT_W of the attached sequencer.
// ---------------------------------------------------------------------------
interface mem_access_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             REQ;
  logic             IOD;
  logic             WR;
  logic [31:0]      PC;
  logic [31:0]      ALUOUT;
  logic [31:0]      WDATA;
  logic [31:0]      MRD;
  logic [31:0]      MRA;
  logic             MWE;
  logic [31:0]      MWD;
  logic [31:0]      IR;
  logic [31:0]      MDR;
  logic             BUSY;
  logic             DONE;
  logic             ERR;
  logic [CNT_W-1:0] ACC_CNT;

  // Sequencer side.
  modport slave (
    input  REQ, IOD, WR, PC, ALUOUT, WDATA, MRD,
    output MRA, MWE, MWD, IR, MDR, BUSY, DONE, ERR, ACC_CNT
  );

  // Requester / memory side.
  modport master (
    output REQ, IOD, WR, PC, ALUOUT, WDATA, MRD,
    input  MRA, MWE, MWD, IR, MDR, BUSY, DONE, ERR, ACC_CNT
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
// Multicycle memory-access sequencer in front of the unified instruction/data
// memory. A request accepted in IDLE selects PC (fetch) or ALUOUT (data),
// converts the byte address to a word index, and runs IDLE -> ACCESS -> DONE.
// Stores assert MWE during ACCESS; reads capture MRD into IR (fetch) or MDR
// (data load) at the end of ACCESS. Misaligned or out-of-range addresses
// fault: no write, no capture, ERR reported with DONE.
//
// Ports:
//   CLK    in  system clock, rising edge
//   RST_N  in  asynchronous active-low reset
//   bus    mem_access_ctrl_if.slave (request, memory and status signals)
// ---------------------------------------------------------------------------
module mem_access_ctrl #(
  parameter int MEM_DEPTH  = 526,
  parameter int ADDR_SHIFT = 2,
  parameter int CNT_W      = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  mem_access_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t           state_reg, state_next;

  logic [31:0]      mra_reg;
  logic [31:0]      mwd_reg;
  logic             store_reg;    // latched IOD & WR
  logic             data_reg;     // latched IOD: capture into MDR instead of IR
  logic             err_reg;
  logic [31:0]      ir_reg;
  logic [31:0]      mdr_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [31:0]      addr_sel;
  logic [31:0]      word_idx;
  logic             fault;
  logic             accept;

  assign addr_sel = bus.IOD ? bus.ALUOUT : bus.PC;
  assign word_idx = addr_sel >> ADDR_SHIFT;
  assign fault    = (|addr_sel[ADDR_SHIFT-1:0]) || (word_idx >= 32'(MEM_DEPTH));
  assign accept   = (state_reg == S_IDLE) && bus.REQ;

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and state-decoded outputs. MWE is decoded from the state so
  // an asynchronous reset removes it immediately, aborting the write.
  always_comb begin
    state_next = state_reg;
    bus.MWE    = 1'b0;
    bus.BUSY   = 1'b0;
    bus.DONE   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (bus.REQ) begin
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        bus.BUSY   = 1'b1;
        bus.MWE    = store_reg && !err_reg;
        state_next = S_DONE;
      end
      S_DONE: begin
        bus.BUSY   = 1'b1;
        bus.DONE   = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mra_reg   <= '0;
      mwd_reg   <= '0;
      store_reg <= 1'b0;
      data_reg  <= 1'b0;
      err_reg   <= 1'b0;
      ir_reg    <= '0;
      mdr_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      if (accept) begin
        mra_reg   <= word_idx;
        mwd_reg   <= bus.WDATA;
        store_reg <= bus.IOD & bus.WR;   // WR without IOD is a plain fetch
        data_reg  <= bus.IOD;
        err_reg   <= fault;
      end

      // Read capture at the end of ACCESS; faulted reads leave both untouched.
      if ((state_reg == S_ACCESS) && !store_reg && !err_reg) begin
        if (data_reg) begin
          mdr_reg <= bus.MRD;
        end else begin
          ir_reg  <= bus.MRD;
        end
      end

      if ((state_reg == S_DONE) && !err_reg) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign bus.MRA     = mra_reg;
  assign bus.MWD     = mwd_reg;
  assign bus.IR      = ir_reg;
  assign bus.MDR     = mdr_reg;
  assign bus.ERR     = err_reg;
  assign bus.ACC_CNT = cnt_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_access_ctrl
// Scoreboard bench for mem_access_ctrl. Stimulus pushes hand-computed
// expectations; a monitor pops one per DONE pulse and compares. A second
// instance with a 4-bit counter shadows the same traffic to exercise wrap.
// ---------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int DEPTH = 526;

  logic CLK;
  logic rst_n;
  logic mem_load;

  mem_access_ctrl_if #(.CNT_W(16)) bus ();
  mem_access_ctrl_if #(.CNT_W(4))  bus_s ();

  mem_access_ctrl #(.MEM_DEPTH(DEPTH), .ADDR_SHIFT(2), .CNT_W(16)) dut (
    .CLK   (CLK),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );

  mem_access_ctrl #(.MEM_DEPTH(DEPTH), .ADDR_SHIFT(2), .CNT_W(4)) dut_s (
    .CLK   (CLK),
    .RST_N (rst_n),
    .bus   (bus_s.slave)
  );

  // Shadow instance sees identical traffic.
  assign bus_s.REQ    = bus.REQ;
  assign bus_s.IOD    = bus.IOD;
  assign bus_s.WR     = bus.WR;
  assign bus_s.PC     = bus.PC;
  assign bus_s.ALUOUT = bus.ALUOUT;
  assign bus_s.WDATA  = bus.WDATA;
  assign bus_s.MRD    = bus.MRD;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: combinational read, write on rising edge.
  logic [31:0] mem [0:DEPTH-1];
  assign bus.MRD = (bus.MRA < 32'(DEPTH)) ? mem[bus.MRA] : 32'h0;

  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem[512] <= 32'h8C08_0000;
    end else if (bus.MWE && (bus.MRA < 32'(DEPTH))) begin
      mem[bus.MRA] <= bus.MWD;
    end
  end

  typedef struct {
    logic [31:0] mra;
    logic [31:0] mwd;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic        err;
    int          we;
  } exp_t;

  exp_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_txn = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] mra, input logic [31:0] mwd,
                              input logic [31:0] ir, input logic [31:0] mdr,
                              input logic err, input int we);
    exp_t e;
    e.mra = mra; e.mwd = mwd; e.ir = ir; e.mdr = mdr; e.err = err; e.we = we;
    return e;
  endfunction

  // Monitor: compares on every DONE pulse.
  int mon_cnt = 0;
  int we_cnt  = 0;
  always @(negedge CLK) begin
    exp_t e;
    if (!rst_n) begin
      mon_cnt = 0;
      we_cnt  = 0;
    end else begin
      if (bus.MWE) we_cnt++;
      if (bus.DONE) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: DONE with empty scoreboard");
        end else begin
          e = sb.pop_front();
          n_txn++;
          $display("txn %0d: mra=%0d mwd=%h ir=%h mdr=%h err=%0d we_cycles=%0d cnt=%0d",
                   n_txn, bus.MRA, bus.MWD, bus.IR, bus.MDR, bus.ERR, we_cnt, bus.ACC_CNT);
          chk("mra", bus.MRA, e.mra);
          chk("mwd", bus.MWD, e.mwd);
          chk("ir", bus.IR, e.ir);
          chk("mdr", bus.MDR, e.mdr);
          chk("err", 32'(bus.ERR), 32'(e.err));
          chk("mwe_cycles", 32'(we_cnt), 32'(e.we));
          chk("busy_in_done", 32'(bus.BUSY), 32'd1);
          chk("acc_cnt", 32'(bus.ACC_CNT), 32'(mon_cnt));
          chk("acc_cnt_w4", 32'(bus_s.ACC_CNT), 32'(mon_cnt % 16));
          if (!e.err) mon_cnt++;
        end
        we_cnt = 0;
      end
    end
  end

  // Waits (bounded) until DONE is seen at a falling edge.
  task automatic wait_done();
    bit got = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.DONE) begin
        got = 1;
        break;
      end
      @(negedge CLK);
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: DONE not seen within 8 cycles");
    end
  endtask

  task automatic issue(input logic iod, input logic wr, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] wd, input exp_t e);
    @(negedge CLK);
    bus.IOD = iod; bus.WR = wr; bus.PC = pc; bus.ALUOUT = alu; bus.WDATA = wd;
    bus.REQ = 1'b1;
    sb.push_back(e);
    @(negedge CLK);
    bus.REQ = 1'b0;
    chk("busy_in_access", 32'(bus.BUSY), 32'd1);
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int last;
    rst_n = 1'b0; mem_load = 1'b1;
    bus.REQ = 1'b0; bus.IOD = 1'b0; bus.WR = 1'b0;
    bus.PC = '0; bus.ALUOUT = '0; bus.WDATA = '0;
    repeat (3) @(negedge CLK);
    mem_load = 1'b0;
    // Reset state
    chk("rst_mra", bus.MRA, 32'h0);
    chk("rst_ir", bus.IR, 32'h0);
    chk("rst_mdr", bus.MDR, 32'h0);
    chk("rst_cnt", 32'(bus.ACC_CNT), 32'h0);
    chk("rst_flags", {28'h0, bus.MWE, bus.BUSY, bus.DONE, bus.ERR}, 32'h0);
    rst_n = 1'b1;

    // 1: fetch Mem[512]
    issue(1'b0, 1'b0, 32'h800, 32'h0, 32'h1111_1111,
          mk(32'd512, 32'h1111_1111, 32'h8C08_0000, 32'h0, 1'b0, 0));
    // WR with IOD=0 is a fetch read
    issue(1'b0, 1'b1, 32'h4, 32'h10, 32'h2222_2222,
          mk(32'd1, 32'h2222_2222, 32'hA500_0001, 32'h0, 1'b0, 0));
    chk("fetch_wr_no_write", mem[1], 32'hA500_0001);
    // 2: store then load
    issue(1'b1, 1'b1, 32'h0, 32'h10, 32'hDEAD_BEEF,
          mk(32'd4, 32'hDEAD_BEEF, 32'hA500_0001, 32'h0, 1'b0, 1));
    chk("store_mem4", mem[4], 32'hDEAD_BEEF);
    issue(1'b1, 1'b0, 32'h0, 32'h10, 32'h0,
          mk(32'd4, 32'h0, 32'hA500_0001, 32'hDEAD_BEEF, 1'b0, 0));
    // 3: misaligned store
    issue(1'b1, 1'b1, 32'h0, 32'h13, 32'h1234_5678,
          mk(32'd4, 32'h1234_5678, 32'hA500_0001, 32'hDEAD_BEEF, 1'b1, 0));
    chk("misaligned_mem4", mem[4], 32'hDEAD_BEEF);
    // misaligned fetch
    issue(1'b0, 1'b0, 32'h802, 32'h0, 32'h0,
          mk(32'd512, 32'h0, 32'hA500_0001, 32'hDEAD_BEEF, 1'b1, 0));
    // 4: out of range, ERR held in IDLE, then last valid word
    issue(1'b1, 1'b0, 32'h0, 32'h838, 32'h0,
          mk(32'd526, 32'h0, 32'hA500_0001, 32'hDEAD_BEEF, 1'b1, 0));
    @(negedge CLK);
    chk("err_held_1", 32'(bus.ERR), 32'd1);
    @(negedge CLK);
    chk("err_held_2", 32'(bus.ERR), 32'd1);
    chk("idle_not_busy", 32'(bus.BUSY), 32'd0);
    issue(1'b1, 1'b0, 32'h0, 32'h834, 32'h0,
          mk(32'd525, 32'h0, 32'hA500_0001, 32'hA500_020D, 1'b0, 0));

    // 6: REQ held high -> DONE every 3rd cycle; 5 + 12 = 17 accesses total
    @(negedge CLK);
    bus.IOD = 1'b1; bus.WR = 1'b0; bus.ALUOUT = 32'h10; bus.WDATA = 32'h5555_0000;
    bus.REQ = 1'b1;
    for (int i = 0; i < 12; i++)
      sb.push_back(mk(32'd4, 32'h5555_0000, 32'hA500_0001, 32'hDEAD_BEEF, 1'b0, 0));
    seen = 0;
    last = -1;
    for (int c = 0; c < 60 && seen < 12; c++) begin
      @(negedge CLK);
      if (bus.DONE) begin
        if (last >= 0) chk("done_spacing", 32'(c - last), 32'd3);
        last = c;
        seen++;
        if (seen == 12) bus.REQ = 1'b0;
      end
    end
    chk("held_done_count", 32'(seen), 32'd12);
    @(negedge CLK);
    chk("cnt_after_held", 32'(bus.ACC_CNT), 32'd17);
    chk("cnt_w4_wrapped", 32'(bus_s.ACC_CNT), 32'd1);
    @(negedge CLK);
    chk("no_extra_access", {30'h0, bus.BUSY, bus.DONE}, 32'h0);

    // 5: reset during ACCESS of a store to word 8
    @(negedge CLK);
    bus.IOD = 1'b1; bus.WR = 1'b1; bus.ALUOUT = 32'h20; bus.WDATA = 32'hCAFE_F00D;
    bus.REQ = 1'b1;
    @(negedge CLK);
    bus.REQ = 1'b0;
    chk("mwe_before_rst", 32'(bus.MWE), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mwe_async_drop", 32'(bus.MWE), 32'd0);
    chk("rst2_mra", bus.MRA, 32'h0);
    chk("rst2_mwd", bus.MWD, 32'h0);
    chk("rst2_ir", bus.IR, 32'h0);
    chk("rst2_mdr", bus.MDR, 32'h0);
    chk("rst2_cnt", 32'(bus.ACC_CNT), 32'h0);
    chk("rst2_flags", {29'h0, bus.BUSY, bus.DONE, bus.ERR}, 32'h0);
    @(negedge CLK);
    @(negedge CLK);
    chk("rst_no_write", mem[8], 32'hA500_0008);
    chk("rst_no_done", 32'(bus.DONE), 32'd0);
    rst_n = 1'b1;

    // Recovery fetch after reset
    issue(1'b0, 1'b0, 32'h800, 32'h0, 32'h1111_1111,
          mk(32'd512, 32'h1111_1111, 32'h8C08_0000, 32'h0, 1'b0, 0));
    @(negedge CLK);
    chk("cnt_after_recovery", 32'(bus.ACC_CNT), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
